ram_port_arbiter: RTL and testbench

- Shares the single synchronous RAM port between instruction fetch (IF) and data access (MEM load/store).
- Serialises requests, holds RAM address, write data and byte enables stable for the whole access, and returns read data to the owning requester.
- Drives the pipeline stall request.
- Load data returned on data_rdata is the raw 32-bit word. Byte extraction and sign extension stay in the write-back stage.

---
 rtl/ram_port_arbiter_pkg.sv | 22 ++
 rtl/ram_port_arbiter_if.sv | 40 ++++
 rtl/ram_port_arbiter_wait_counter.sv | 31 +++
 rtl/ram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter: bus widths, FSM states,
// grant identifiers and the store byte-enable helper.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  function automatic logic [SEL_W-1:0] write_mask(input logic we, input logic [SEL_W-1:0] sel);
    return we ? sel : {SEL_W{1'b0}};
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundles the fetch, data, RAM and stall signals around the arbiter.
// slave = arbiter view, master = pipeline/RAM environment view.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_done;
  logic              data_req;
  logic              data_we;
  logic [SEL_W-1:0]  data_sel;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_done;
  logic              ram_en;
  logic [SEL_W-1:0]  ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  logic              stall_req;
  logic              bus_err;

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_sel, data_addr, data_wdata,
           ram_rdata, ram_ready,
    output inst_rdata, inst_done, data_rdata, data_done, ram_en, ram_we, ram_addr,
           ram_wdata, stall_req, bus_err
  );

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_sel, data_addr, data_wdata,
           ram_rdata, ram_ready,
    input  inst_rdata, inst_done, data_rdata, data_done, ram_en, ram_we, ram_addr,
           ram_wdata, stall_req, bus_err
  );

endinterface

// File: rtl/ram_port_arbiter_wait_counter.sv
// Wait-for-ready counter: synchronous clear, count enable, and a terminal flag
// raised once the count sits at TIMEOUT_CYCLES - 1.
module arb_wait_counter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_WIDTH-1:0] cnt_r;

  // Count register; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign terminal = (cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one synchronous RAM port,
// holding the access registered until ram_ready or a forced timeout completion.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input logic               clk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);

  arb_state_t        state_r, state_s;
  logic              last_grant_r, last_grant_s;
  logic              access_we_r, access_we_s;
  logic              ram_en_r, ram_en_s;
  logic [SEL_W-1:0]  ram_we_r, ram_we_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_r, ram_wdata_s;
  logic [DATA_W-1:0] inst_rdata_r, inst_rdata_s;
  logic [DATA_W-1:0] data_rdata_r, data_rdata_s;
  logic              inst_done_r, inst_done_s;
  logic              data_done_r, data_done_s;
  logic              bus_err_r, bus_err_s;
  logic              cnt_clear_s, cnt_enable_s, cnt_terminal_s;
  logic              inst_ok_s, data_ok_s;

  // A requester whose done pulse is showing must not be re-granted at the next edge.
  assign inst_ok_s = bus.inst_req & ~inst_done_r;
  assign data_ok_s = bus.data_req & ~data_done_r;

  arb_wait_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear_s),
    .enable   (cnt_enable_s),
    .terminal (cnt_terminal_s)
  );

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    access_we_s  = access_we_r;
    ram_en_s     = ram_en_r;
    ram_we_s     = ram_we_r;
    ram_addr_s   = ram_addr_r;
    ram_wdata_s  = ram_wdata_r;
    inst_rdata_s = inst_rdata_r;
    data_rdata_s = data_rdata_r;
    inst_done_s  = 1'b0;
    data_done_s  = 1'b0;
    bus_err_s    = 1'b0;
    cnt_clear_s  = 1'b0;
    cnt_enable_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (data_ok_s && (!inst_ok_s || (last_grant_r == GRANT_INST))) begin
          state_s      = ARB_BUSY_D;
          last_grant_s = GRANT_DATA;
          access_we_s  = bus.data_we;
          ram_en_s     = 1'b1;
          ram_we_s     = write_mask(bus.data_we, bus.data_sel);
          ram_addr_s   = bus.data_addr;
          ram_wdata_s  = bus.data_wdata;
          cnt_clear_s  = 1'b1;
        end else if (inst_ok_s) begin
          state_s      = ARB_BUSY_I;
          last_grant_s = GRANT_INST;
          access_we_s  = 1'b0;
          ram_en_s     = 1'b1;
          ram_we_s     = {SEL_W{1'b0}};
          ram_addr_s   = bus.inst_addr;
          ram_wdata_s  = {DATA_W{1'b0}};
          cnt_clear_s  = 1'b1;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // A ready in the terminal cycle still counts as a normal completion.
        if (bus.ram_ready || cnt_terminal_s) begin
          state_s   = ARB_IDLE;
          ram_en_s  = 1'b0;
          ram_we_s  = {SEL_W{1'b0}};
          bus_err_s = ~bus.ram_ready;
          if (state_r == ARB_BUSY_I) begin
            inst_done_s  = 1'b1;
            inst_rdata_s = bus.ram_ready ? bus.ram_rdata : {DATA_W{1'b0}};
          end else begin
            data_done_s  = 1'b1;
            data_rdata_s = (bus.ram_ready && !access_we_r) ? bus.ram_rdata : {DATA_W{1'b0}};
          end
        end else begin
          cnt_enable_s = 1'b1;
        end
      end
      default: begin
        state_s  = ARB_IDLE;
        ram_en_s = 1'b0;
        ram_we_s = {SEL_W{1'b0}};
      end
    endcase
  end

  // State and registered-output update; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= GRANT_INST;
      access_we_r  <= 1'b0;
      ram_en_r     <= 1'b0;
      ram_we_r     <= {SEL_W{1'b0}};
      ram_addr_r   <= {ADDR_W{1'b0}};
      ram_wdata_r  <= {DATA_W{1'b0}};
      inst_rdata_r <= {DATA_W{1'b0}};
      data_rdata_r <= {DATA_W{1'b0}};
      inst_done_r  <= 1'b0;
      data_done_r  <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      access_we_r  <= access_we_s;
      ram_en_r     <= ram_en_s;
      ram_we_r     <= ram_we_s;
      ram_addr_r   <= ram_addr_s;
      ram_wdata_r  <= ram_wdata_s;
      inst_rdata_r <= inst_rdata_s;
      data_rdata_r <= data_rdata_s;
      inst_done_r  <= inst_done_s;
      data_done_r  <= data_done_s;
      bus_err_r    <= bus_err_s;
    end
  end

  assign bus.ram_en     = ram_en_r;
  assign bus.ram_we     = ram_we_r;
  assign bus.ram_addr   = ram_addr_r;
  assign bus.ram_wdata  = ram_wdata_r;
  assign bus.inst_rdata = inst_rdata_r;
  assign bus.data_rdata = data_rdata_r;
  assign bus.inst_done  = inst_done_r;
  assign bus.data_done  = data_done_r;
  assign bus.bus_err    = bus_err_r;
  assign bus.stall_req  = (bus.inst_req & ~inst_done_r) | (bus.data_req & ~data_done_r);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: fetch, contention/alternation, byte store,
// address change mid-access, timeout and reset mid-access.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  ram_port_arbiter_if bus_if ();

  ram_port_arbiter #(
    .TIMEOUT_CYCLES (16),
    .CNT_WIDTH      (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus_if.inst_req   = 1'b0;
    bus_if.inst_addr  = 32'h0;
    bus_if.data_req   = 1'b0;
    bus_if.data_we    = 1'b0;
    bus_if.data_sel   = 4'h0;
    bus_if.data_addr  = 32'h0;
    bus_if.data_wdata = 32'h0;
    bus_if.ram_rdata  = 32'h0;
    bus_if.ram_ready  = 1'b0;
    tick();
    tick();
    check("rst_ram_en", {31'h0, bus_if.ram_en}, 32'h0);
    check("rst_ram_we", {28'h0, bus_if.ram_we}, 32'h0);
    check("rst_ram_addr", bus_if.ram_addr, 32'h0);
    check("rst_dones", {30'h0, bus_if.inst_done, bus_if.data_done}, 32'h0);
    check("rst_bus_err", {31'h0, bus_if.bus_err}, 32'h0);
    check("rst_stall", {31'h0, bus_if.stall_req}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Fetch only, ready two cycles after ram_en rises.
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'h0040_0000;
    #1;
    check("f_stall_req", {31'h0, bus_if.stall_req}, 32'h1);
    tick();
    check("f_en_c0", {31'h0, bus_if.ram_en}, 32'h1);
    check("f_addr", bus_if.ram_addr, 32'h0040_0000);
    check("f_we", {28'h0, bus_if.ram_we}, 32'h0);
    tick();
    check("f_en_c1", {31'h0, bus_if.ram_en}, 32'h1);
    tick();
    check("f_en_c2", {31'h0, bus_if.ram_en}, 32'h1);
    check("f_no_done_c2", {31'h0, bus_if.inst_done}, 32'h0);
    bus_if.ram_ready = 1'b1;
    bus_if.ram_rdata = 32'h3C01_1234;
    tick();
    bus_if.ram_ready = 1'b0;
    check("f_en_c3", {31'h0, bus_if.ram_en}, 32'h0);
    check("f_done", {31'h0, bus_if.inst_done}, 32'h1);
    check("f_rdata", bus_if.inst_rdata, 32'h3C01_1234);
    check("f_stall_done", {31'h0, bus_if.stall_req}, 32'h0);
    check("f_bus_err", {31'h0, bus_if.bus_err}, 32'h0);
    tick();
    check("f_done_pulse", {31'h0, bus_if.inst_done}, 32'h0);
    check("f_no_regrant", {31'h0, bus_if.ram_en}, 32'h0);
    check("f_rdata_hold", bus_if.inst_rdata, 32'h3C01_1234);
    bus_if.inst_req = 1'b0;
    tick();

    // Contention straight after reset: data first, inst after one idle cycle.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'h0040_0004;
    bus_if.data_req  = 1'b1;
    bus_if.data_we   = 1'b0;
    bus_if.data_sel  = 4'hF;
    bus_if.data_addr = 32'h1000_0000;
    tick();
    check("p1_data_first", bus_if.ram_addr, 32'h1000_0000);
    check("p1_load_we", {28'h0, bus_if.ram_we}, 32'h0);
    bus_if.ram_ready = 1'b1;
    bus_if.ram_rdata = 32'hDEAD_BEEF;
    tick();
    bus_if.ram_ready = 1'b0;
    check("p1_data_done", {31'h0, bus_if.data_done}, 32'h1);
    check("p1_data_rdata", bus_if.data_rdata, 32'hDEAD_BEEF);
    check("p1_idle_gap", {31'h0, bus_if.ram_en}, 32'h0);
    check("p1_stall_inst", {31'h0, bus_if.stall_req}, 32'h1);
    bus_if.data_req = 1'b0;
    tick();
    check("p1_inst_second", bus_if.ram_addr, 32'h0040_0004);
    check("p1_inst_en", {31'h0, bus_if.ram_en}, 32'h1);
    bus_if.ram_ready = 1'b1;
    bus_if.ram_rdata = 32'h1111_2222;
    tick();
    bus_if.ram_ready = 1'b0;
    bus_if.inst_req  = 1'b0;
    check("p1_inst_rdata", bus_if.inst_rdata, 32'h1111_2222);
    check("p1_data_hold", bus_if.data_rdata, 32'hDEAD_BEEF);

    // Byte store; requester changes address and data mid-access.
    bus_if.data_req   = 1'b1;
    bus_if.data_we    = 1'b1;
    bus_if.data_sel   = 4'b0100;
    bus_if.data_wdata = 32'h00AB_0000;
    bus_if.data_addr  = 32'h1000_0002;
    tick();
    check("st_we", {28'h0, bus_if.ram_we}, 32'h4);
    check("st_addr", bus_if.ram_addr, 32'h1000_0002);
    check("st_wdata", bus_if.ram_wdata, 32'h00AB_0000);
    bus_if.data_addr  = 32'h2000_0000;
    bus_if.data_wdata = 32'hFFFF_FFFF;
    bus_if.data_sel   = 4'hF;
    tick();
    check("st_addr_held", bus_if.ram_addr, 32'h1000_0002);
    check("st_wdata_held", bus_if.ram_wdata, 32'h00AB_0000);
    check("st_we_held", {28'h0, bus_if.ram_we}, 32'h4);
    bus_if.ram_ready = 1'b1;
    bus_if.ram_rdata = 32'hCAFE_F00D;
    tick();
    bus_if.ram_ready = 1'b0;
    check("st_done", {31'h0, bus_if.data_done}, 32'h1);
    check("st_rdata_zero", bus_if.data_rdata, 32'h0);
    bus_if.data_req = 1'b0;
    bus_if.data_we  = 1'b0;
    tick();

    // Second contention after a data grant: inst wins this time.
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'h0040_0008;
    bus_if.data_req  = 1'b1;
    bus_if.data_addr = 32'h1000_0010;
    tick();
    check("p2_inst_first", bus_if.ram_addr, 32'h0040_0008);
    bus_if.ram_ready = 1'b1;
    bus_if.ram_rdata = 32'h55AA_55AA;
    tick();
    bus_if.ram_ready = 1'b0;
    bus_if.inst_req  = 1'b0;
    check("p2_inst_rdata", bus_if.inst_rdata, 32'h55AA_55AA);
    check("p2_no_data_done", {31'h0, bus_if.data_done}, 32'h0);
    tick();
    check("p2_data_second", bus_if.ram_addr, 32'h1000_0010);
    bus_if.ram_ready = 1'b1;
    bus_if.ram_rdata = 32'h0102_0304;
    tick();
    bus_if.ram_ready = 1'b0;
    bus_if.data_req  = 1'b0;
    check("p2_data_rdata", bus_if.data_rdata, 32'h0102_0304);
    tick();

    // Timeout: ram_ready never arrives.
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'h0040_0010;
    tick();
    check("to_en", {31'h0, bus_if.ram_en}, 32'h1);
    n = 0;
    while (!bus_if.inst_done && n < 40) begin
      check("to_no_err_early", {31'h0, bus_if.bus_err}, 32'h0);
      tick();
      n++;
    end
    check("to_latency", n, 32'd16);
    check("to_bus_err", {31'h0, bus_if.bus_err}, 32'h1);
    check("to_done", {31'h0, bus_if.inst_done}, 32'h1);
    check("to_rdata_zero", bus_if.inst_rdata, 32'h0);
    check("to_en_low", {31'h0, bus_if.ram_en}, 32'h0);
    bus_if.inst_req = 1'b0;
    tick();
    check("to_err_pulse", {31'h0, bus_if.bus_err}, 32'h0);

    // Reset in the middle of a data access, then a stray late ready.
    bus_if.data_req  = 1'b1;
    bus_if.data_addr = 32'h1000_0020;
    tick();
    check("rm_busy_en", {31'h0, bus_if.ram_en}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_en_async", {31'h0, bus_if.ram_en}, 32'h0);
    bus_if.data_req  = 1'b0;
    bus_if.ram_ready = 1'b1;
    bus_if.ram_rdata = 32'h7777_7777;
    tick();
    rst_n = 1'b1;
    tick();
    check("rm_no_done", {31'h0, bus_if.data_done}, 32'h0);
    check("rm_late_ready_en", {31'h0, bus_if.ram_en}, 32'h0);
    check("rm_rdata", bus_if.data_rdata, 32'h0);
    bus_if.ram_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
